accelerator_read_keys_sequencer: RTL

ACCELERATOR_READ_KEYS_SEQUENCER -- requirements
Module: accelerator_read_keys_sequencer

---
 rtl/accelerator_dnc_pkg.sv | 17 +
 rtl/accelerator_index_counter_2d.sv | 55 +++++
 rtl/accelerator_read_keys_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/accelerator_dnc_pkg.sv
// rtl/accelerator_dnc_pkg.sv - shared FSM encoding and constants for the key read sequencer
package accelerator_dnc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   localparam logic CTRL_ZERO = 1'b0;
   localparam logic CTRL_ONE  = 1'b1;
   localparam int   DATA_ZERO = 0;
   localparam int   DATA_ONE  = 1;

endpackage

// File: rtl/accelerator_index_counter_2d.sv
// rtl/accelerator_index_counter_2d.sv - nested head/word counter, k inner, wraps to 0,0 after the last element
module accelerator_index_counter_2d
   import accelerator_dnc_pkg::*;
#(
   parameter int CONTROL_SIZE = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    advance,
   input  logic [CONTROL_SIZE-1:0] r_max,
   input  logic [CONTROL_SIZE-1:0] w_max,
   output logic [CONTROL_SIZE-1:0] i,
   output logic [CONTROL_SIZE-1:0] k,
   output logic                    last
);

   logic [CONTROL_SIZE-1:0] i_q, i_d;
   logic [CONTROL_SIZE-1:0] k_q, k_d;
   logic                    k_wrap;
   logic                    i_wrap;

   always_comb begin
      k_wrap = (k_q == w_max);
      i_wrap = (i_q == r_max);
      i_d    = i_q;
      k_d    = k_q;
      if (clear) begin
         i_d = CONTROL_SIZE'(DATA_ZERO);
         k_d = CONTROL_SIZE'(DATA_ZERO);
      end else if (advance) begin
         if (!k_wrap) begin
            k_d = k_q + CONTROL_SIZE'(DATA_ONE);
         end else begin
            k_d = CONTROL_SIZE'(DATA_ZERO);
            i_d = i_wrap ? CONTROL_SIZE'(DATA_ZERO) : i_q + CONTROL_SIZE'(DATA_ONE);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_q <= CONTROL_SIZE'(DATA_ZERO);
         k_q <= CONTROL_SIZE'(DATA_ZERO);
      end else begin
         i_q <= i_d;
         k_q <= k_d;
      end
   end

   assign i    = i_q;
   assign k    = k_q;
   assign last = k_wrap & i_wrap;

endmodule

// File: rtl/accelerator_read_keys_sequencer.sv
// rtl/accelerator_read_keys_sequencer.sv - streams an R x W key block from key memory to the downstream key stage
module accelerator_read_keys_sequencer
   import accelerator_dnc_pkg::*;
#(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   input  logic                    ABORT,
   output logic                    READY,
   output logic                    ERROR,
   input  logic [DATA_SIZE-1:0]    SIZE_R_IN,
   input  logic [DATA_SIZE-1:0]    SIZE_W_IN,
   output logic                    KEY_RD_EN,
   output logic [CONTROL_SIZE-1:0] KEY_ADDR_I,
   output logic [CONTROL_SIZE-1:0] KEY_ADDR_K,
   input  logic [DATA_SIZE-1:0]    KEY_RD_DATA,
   input  logic                    DS_BUSY,
   output logic [DATA_SIZE-1:0]    K_OUT,
   output logic                    K_OUT_I_ENABLE,
   output logic                    K_OUT_K_ENABLE
);

   seq_state_t              state_q, state_d;
   logic [CONTROL_SIZE-1:0] r_max_q, r_max_d;
   logic [CONTROL_SIZE-1:0] w_max_q, w_max_d;
   logic [CONTROL_SIZE-1:0] addr_i_q, addr_i_d;
   logic [CONTROL_SIZE-1:0] addr_k_q, addr_k_d;
   logic [DATA_SIZE-1:0]    elem_q, elem_d;
   logic [DATA_SIZE-1:0]    k_out_q, k_out_d;
   logic                    rd_en_q, rd_en_d;
   logic                    ready_q, ready_d;
   logic                    error_q, error_d;
   logic                    k_en_q, k_en_d;
   logic                    i_en_q, i_en_d;
   logic                    last_q, last_d;
   logic                    cnt_clear, cnt_advance;
   logic [CONTROL_SIZE-1:0] cnt_i, cnt_k;
   logic                    cnt_last;
   logic                    sizes_ok;

   accelerator_index_counter_2d #(
      .CONTROL_SIZE(CONTROL_SIZE)
   ) u_index (
      .clk    (CLK),
      .rst    (RST),
      .clear  (cnt_clear),
      .advance(cnt_advance),
      .r_max  (r_max_q),
      .w_max  (w_max_q),
      .i      (cnt_i),
      .k      (cnt_k),
      .last   (cnt_last)
   );

   assign sizes_ok = (SIZE_R_IN != DATA_SIZE'(DATA_ZERO)) && (SIZE_W_IN != DATA_SIZE'(DATA_ZERO));

   // Strobes are launched on the edge leaving WAIT (or a stalled ISSUE), so the
   // element is visible during ISSUE; the counter moves on at launch, and the
   // last flag is kept so ISSUE knows whether to finish or fetch again.
   always_comb begin
      state_d     = state_q;
      r_max_d     = r_max_q;
      w_max_d     = w_max_q;
      addr_i_d    = addr_i_q;
      addr_k_d    = addr_k_q;
      elem_d      = elem_q;
      k_out_d     = k_out_q;
      rd_en_d     = CTRL_ZERO;
      ready_d     = CTRL_ZERO;
      error_d     = CTRL_ZERO;
      k_en_d      = CTRL_ZERO;
      i_en_d      = CTRL_ZERO;
      last_d      = last_q;
      cnt_clear   = CTRL_ZERO;
      cnt_advance = CTRL_ZERO;

      if (ABORT && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         cnt_clear = CTRL_ONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (START) begin
                  if (sizes_ok) begin
                     r_max_d   = CONTROL_SIZE'(SIZE_R_IN) - CONTROL_SIZE'(DATA_ONE);
                     w_max_d   = CONTROL_SIZE'(SIZE_W_IN) - CONTROL_SIZE'(DATA_ONE);
                     cnt_clear = CTRL_ONE;
                     rd_en_d   = CTRL_ONE;
                     addr_i_d  = CONTROL_SIZE'(DATA_ZERO);
                     addr_k_d  = CONTROL_SIZE'(DATA_ZERO);
                     state_d   = ST_FETCH;
                  end else begin
                     error_d = CTRL_ONE;
                  end
               end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
               elem_d  = KEY_RD_DATA;
               state_d = ST_ISSUE;
               if (!DS_BUSY) begin
                  k_out_d     = KEY_RD_DATA;
                  k_en_d      = CTRL_ONE;
                  i_en_d      = (cnt_k == CONTROL_SIZE'(DATA_ZERO));
                  last_d      = cnt_last;
                  cnt_advance = CTRL_ONE;
               end
            end
            ST_ISSUE: begin
               if (k_en_q) begin
                  if (last_q) begin
                     state_d = ST_DONE;
                     ready_d = CTRL_ONE;
                  end else begin
                     state_d  = ST_FETCH;
                     rd_en_d  = CTRL_ONE;
                     addr_i_d = cnt_i;
                     addr_k_d = cnt_k;
                  end
               end else if (!DS_BUSY) begin
                  k_out_d     = elem_q;
                  k_en_d      = CTRL_ONE;
                  i_en_d      = (cnt_k == CONTROL_SIZE'(DATA_ZERO));
                  last_d      = cnt_last;
                  cnt_advance = CTRL_ONE;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         r_max_q  <= CONTROL_SIZE'(DATA_ZERO);
         w_max_q  <= CONTROL_SIZE'(DATA_ZERO);
         addr_i_q <= CONTROL_SIZE'(DATA_ZERO);
         addr_k_q <= CONTROL_SIZE'(DATA_ZERO);
         elem_q   <= DATA_SIZE'(DATA_ZERO);
         k_out_q  <= DATA_SIZE'(DATA_ZERO);
         rd_en_q  <= CTRL_ZERO;
         ready_q  <= CTRL_ZERO;
         error_q  <= CTRL_ZERO;
         k_en_q   <= CTRL_ZERO;
         i_en_q   <= CTRL_ZERO;
         last_q   <= CTRL_ZERO;
      end else begin
         state_q  <= state_d;
         r_max_q  <= r_max_d;
         w_max_q  <= w_max_d;
         addr_i_q <= addr_i_d;
         addr_k_q <= addr_k_d;
         elem_q   <= elem_d;
         k_out_q  <= k_out_d;
         rd_en_q  <= rd_en_d;
         ready_q  <= ready_d;
         error_q  <= error_d;
         k_en_q   <= k_en_d;
         i_en_q   <= i_en_d;
         last_q   <= last_d;
      end
   end

   assign READY          = ready_q;
   assign ERROR          = error_q;
   assign KEY_RD_EN      = rd_en_q;
   assign KEY_ADDR_I     = addr_i_q;
   assign KEY_ADDR_K     = addr_k_q;
   assign K_OUT          = k_out_q;
   assign K_OUT_I_ENABLE = i_en_q;
   assign K_OUT_K_ENABLE = k_en_q;

endmodule
